// File: rtl/tnoc_output_arbiter_pkg.sv
// Shared NoC router types: port indices, arbiter state and index-width helper.
package tnoc_output_arbiter_pkg;

  localparam int TNOC_ROUTER_PORTS = 5;

  // Bit order of the active-port / request vectors. "local" is reserved in SV.
  typedef enum logic [2:0] {
    tnoc_port_xp    = 3'd0,
    tnoc_port_xm    = 3'd1,
    tnoc_port_yp    = 3'd2,
    tnoc_port_ym    = 3'd3,
    tnoc_port_local = 3'd4
  } tnoc_port_index;

  typedef enum logic {
    arb_idle   = 1'b0,
    arb_locked = 1'b1
  } tnoc_arb_state;

  function automatic int tnoc_index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tnoc_output_arbiter_if.sv
// Request/grant bundle between the router input ports and one output arbiter.
interface tnoc_output_arbiter_if #(
  parameter int REQUESTERS = 5
);
  logic [REQUESTERS-1:0] i_request;
  logic                  i_accept;
  logic                  i_tail;
  logic [REQUESTERS-1:0] o_grant;
  logic                  o_locked;
  logic                  o_timeout;

  modport master (
    output i_request, i_accept, i_tail,
    input  o_grant, o_locked, o_timeout
  );

  modport slave (
    input  i_request, i_accept, i_tail,
    output o_grant, o_locked, o_timeout
  );
endinterface

// File: rtl/tnoc_output_arbiter_selector.sv
// Combinational round-robin pick: first set request after the last winner, wrapping.
module tnoc_round_robin_selector #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          any
);

  logic [IW-1:0] idx;

  // Offset N lands back on the last winner, so it is only chosen when alone.
  always_comb begin
    grant  = '0;
    winner = last;
    any    = 1'b0;
    idx    = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IW'((int'(last) + off) % N);
      if (!any && request[idx]) begin
        grant[idx] = 1'b1;
        winner     = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tnoc_output_arbiter.sv
// Packet-locked round-robin arbiter for one router output port.
// Optional stall watchdog: define TNOC_OUTPUT_ARBITER_WATCHDOG_EN.
module tnoc_output_arbiter
  import tnoc_output_arbiter_pkg::*;
#(
  parameter int REQUESTERS      = TNOC_ROUTER_PORTS,
  parameter int WATCHDOG_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  tnoc_output_arbiter_if.slave arb_if
);

  localparam int IW = tnoc_index_width(REQUESTERS);
  localparam logic [IW-1:0] LAST_RST = IW'(REQUESTERS - 1);

  if (WATCHDOG_CYCLES < 1 || WATCHDOG_CYCLES > 65535) begin : g_bad_cfg
    $error("tnoc_output_arbiter: WATCHDOG_CYCLES out of range 1..65535");
  end

  tnoc_arb_state         state_q, state_d;
  logic [REQUESTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]         last_q, last_d;
  logic                  timeout_q, timeout_d;

  logic [REQUESTERS-1:0] sel_grant;
  logic [IW-1:0]         sel_winner;
  logic                  sel_any;
  logic                  tail_done;
  logic                  wd_expire;

  tnoc_round_robin_selector #(.N(REQUESTERS), .IW(IW)) u_sel (
    .request (arb_if.i_request),
    .last    (last_q),
    .grant   (sel_grant),
    .winner  (sel_winner),
    .any     (sel_any)
  );

  assign tail_done = arb_if.i_accept && arb_if.i_tail;

`ifdef TNOC_OUTPUT_ARBITER_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // Fires on the stall cycle that would bring the count up to the limit.
  assign wd_expire = (state_q == arb_locked) && !arb_if.i_accept &&
                     (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 1));

  always_comb begin
    wd_cnt_d = '0;
    if (state_q == arb_locked && !arb_if.i_accept && !wd_expire)
      wd_cnt_d = wd_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) wd_cnt_q <= '0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      arb_idle: begin
        if (sel_any) begin
          state_d = arb_locked;
          grant_d = sel_grant;
          last_d  = sel_winner;
        end
      end
      arb_locked: begin
        // Tail handoff re-arbitrates in the same cycle: no bubble between packets.
        if (tail_done) begin
          if (sel_any) begin
            grant_d = sel_grant;
            last_d  = sel_winner;
          end else begin
            state_d = arb_idle;
            grant_d = '0;
          end
        end else if (wd_expire) begin
          // last keeps the stalled winner so it drops to lowest priority.
          timeout_d = 1'b1;
          state_d   = arb_idle;
          grant_d   = '0;
        end
      end
      default: begin
        state_d = arb_idle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= arb_idle;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  assign arb_if.o_grant   = grant_q;
  assign arb_if.o_locked  = (state_q == arb_locked);
  assign arb_if.o_timeout = timeout_q;

endmodule

// File: tb/tb_tnoc_output_arbiter.sv
// Directed bench for tnoc_output_arbiter; watchdog leg follows TNOC_OUTPUT_ARBITER_WATCHDOG_EN.
module tb_tnoc_output_arbiter;
  import tnoc_output_arbiter_pkg::*;

  localparam int N  = TNOC_ROUTER_PORTS;
  localparam int WD = 8;

  logic i_clk = 1'b0;
  logic i_rst;
  int   errors = 0;
  int   checks = 0;

  tnoc_output_arbiter_if #(.REQUESTERS(N)) aif ();

  tnoc_output_arbiter #(.REQUESTERS(N), .WATCHDOG_CYCLES(WD)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .arb_if (aif)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic acc, input logic tl);
    aif.i_request = req;
    aif.i_accept  = acc;
    aif.i_tail    = tl;
  endtask

  initial begin
    i_rst = 1'b1;
    drive('0, 1'b0, 1'b0);
    tick;
    tick;
    chk("rst_grant",   32'(aif.o_grant),   32'h0);
    chk("rst_locked",  32'(aif.o_locked),  32'h0);
    chk("rst_timeout", 32'(aif.o_timeout), 32'h0);
    i_rst = 1'b0;

    // First request after reset: one-cycle latency
    drive(5'b00001, 1'b0, 1'b0);
    tick;
    chk("first_grant",  32'(aif.o_grant),  32'h01);
    chk("first_locked", 32'(aif.o_locked), 32'h1);
    drive('0, 1'b1, 1'b1);
    tick;
    chk("tail_none_grant",  32'(aif.o_grant),  32'h0);
    chk("tail_none_locked", 32'(aif.o_locked), 32'h0);

    // Fresh reset, then all requesting with single-flit packets
    i_rst = 1'b1;
    #2;
    i_rst = 1'b0;
    drive(5'b11111, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick;
      chk($sformatf("rr_%0d", k), 32'(aif.o_grant), 32'(1) << (k % N));
      chk($sformatf("rr_lock_%0d", k), 32'(aif.o_locked), 32'h1);
    end
    drive('0, 1'b1, 1'b1);
    tick;
    chk("rr_drain", 32'(aif.o_grant), 32'h0);

    // Input 2 holds a 4-flit packet; requests shift under it
    drive(5'b00100, 1'b0, 1'b0);
    tick;
    chk("pkt_start", 32'(aif.o_grant), 32'h04);
    drive(5'b00100, 1'b1, 1'b0);
    tick;
    chk("pkt_flit1", 32'(aif.o_grant), 32'h04);
    drive(5'b00101, 1'b1, 1'b0);
    tick;
    chk("pkt_flit2", 32'(aif.o_grant), 32'h04);
    drive(5'b00001, 1'b1, 1'b0);
    tick;
    chk("pkt_flit3", 32'(aif.o_grant), 32'h04);
    drive(5'b00001, 1'b0, 1'b0);
    tick;
    chk("pkt_stall", 32'(aif.o_grant), 32'h04);
    drive(5'b00001, 1'b1, 1'b1);
    tick;
    chk("pkt_handoff", 32'(aif.o_grant), 32'h01);

    // Holder re-grant only when alone
    drive(5'b00001, 1'b1, 1'b1);
    tick;
    chk("regrant_alone", 32'(aif.o_grant), 32'h01);
    drive(5'b00011, 1'b1, 1'b1);
    tick;
    chk("regrant_other", 32'(aif.o_grant), 32'h02);
    drive('0, 1'b1, 1'b1);
    tick;
    chk("idle_grant",  32'(aif.o_grant),  32'h0);
    chk("idle_locked", 32'(aif.o_locked), 32'h0);
    tick;
    chk("idle_ignore", 32'(aif.o_grant), 32'h0);

    // Asynchronous reset mid-packet
    drive(5'b11111, 1'b0, 1'b0);
    tick;
    chk("pre_rst_grant", 32'(aif.o_grant), 32'h04);
    #2;
    i_rst = 1'b1;
    #1;
    chk("async_rst_grant",  32'(aif.o_grant),  32'h0);
    chk("async_rst_locked", 32'(aif.o_locked), 32'h0);
    tick;
    chk("rst_held_grant", 32'(aif.o_grant), 32'h0);
    #2;
    i_rst = 1'b0;
    tick;
    chk("post_rst_grant",  32'(aif.o_grant),  32'h01);
    chk("post_rst_locked", 32'(aif.o_locked), 32'h1);

    // Holder stalls with input 3 waiting
    drive(5'b01001, 1'b0, 1'b0);
    repeat (WD - 1) tick;
    chk("stall_grant",   32'(aif.o_grant),   32'h01);
    chk("stall_timeout", 32'(aif.o_timeout), 32'h0);
    tick;
`ifdef TNOC_OUTPUT_ARBITER_WATCHDOG_EN
    chk("wd_timeout", 32'(aif.o_timeout), 32'h1);
    chk("wd_grant",   32'(aif.o_grant),   32'h0);
    chk("wd_locked",  32'(aif.o_locked),  32'h0);
    tick;
    chk("wd_pulse_end", 32'(aif.o_timeout), 32'h0);
    chk("wd_next",      32'(aif.o_grant),   32'h08);
`else
    chk("hold_timeout", 32'(aif.o_timeout), 32'h0);
    chk("hold_grant",   32'(aif.o_grant),   32'h01);
    tick;
    chk("hold_grant2",  32'(aif.o_grant),   32'h01);
    chk("hold_locked",  32'(aif.o_locked),  32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tnoc_output_arbiter.md
# tnoc_output_arbiter

Packet-level round-robin arbiter that shares one router output port among the router's input ports (X+, X−, Y+, Y−, local). One instance per output port inside the router; it drives the output-side multiplexer select. A grant is locked from the first flit of a packet until its tail flit is accepted downstream, so flits of different packets never interleave on a link.

## Interface
Parameters:
- REQUESTERS, 5: number of requesting input ports; index order xp=0, xm=1, yp=2, ym=3, local=4.
- WATCHDOG_CYCLES, 255: stall limit in cycles; used only when the watchdog is compiled in; legal range 1..65535.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; one clock, asynchronous, active-high
- i_request  input  REQUESTERS  per-input request: a flit destined for this output is pending
- i_accept  input  1  output handshake completed this cycle (valid && ready on the output link)
- i_tail  input  1  flit accepted this cycle is a tail flit; qualified by i_accept
- o_grant  output  REQUESTERS  one-hot grant, registered; all-zero when idle
- o_locked  output  1  a packet currently owns the output
- o_timeout  output  1  one-cycle pulse on watchdog release (0 when compiled out)

## Operation
- States: IDLE (o_grant=0, o_locked=0), LOCKED (o_grant one-hot, o_locked=1).
- Round-robin pointer `last` holds the most recent winner index; search order starts at last+1, wraps modulo REQUESTERS; last winner has lowest priority.
- IDLE: if any i_request bit set → select winner, register one-hot o_grant, last←winner, go LOCKED. Else stay.
- LOCKED: hold o_grant regardless of i_request changes (request drop mid-packet ignored).
  - i_accept && !i_tail: stay, grant unchanged.
  - i_accept && i_tail: re-arbitrate same cycle over current i_request. Any request → new grant next cycle (no bubble), stay LOCKED. None → IDLE.
  - Holder re-requesting on its tail cycle wins again only if no other input requests.
- i_accept/i_tail in IDLE are ignored.
- Reset: o_grant=0, o_locked=0, o_timeout=0, last=REQUESTERS−1 (input 0 has first priority), watchdog counter 0.

## Timing
- Request-to-grant latency: 1 cycle (request sampled at edge N, o_grant valid after edge N).
- Tail-to-next-grant: new grant valid the cycle after tail acceptance; output link can accept back-to-back packets.
- All outputs registered; no combinational path from inputs to outputs.
- Reset asserted mid-packet: immediate (asynchronous) return to IDLE with grant cleared; packet in flight is the surrounding logic's concern.

## Configuration
- TNOC_OUTPUT_ARBITER_WATCHDOG_EN defined: counter of width $clog2(WATCHDOG_CYCLES+1) clears on each grant change and each i_accept; increments every LOCKED cycle without i_accept. On reaching WATCHDOG_CYCLES: o_timeout pulses 1 cycle, grant cleared, state IDLE (last keeps the stalled winner so it gets lowest priority), counter cleared.
- Not defined: no counter, o_timeout tied 0, lock held indefinitely.

## Structure
- tnoc_pkg: constant TNOC_ROUTER_PORTS=5; enum tnoc_port_index {xp, xm, yp, ym, local} matching active-port bit order; arbiter state enum.
- Sub-module tnoc_round_robin_selector: combinational one-hot winner from request vector and pointer; reused by the arbiter and any future VC arbiter.

## Test plan
- Reset, then i_request=5'b00001 → o_grant=5'b00001 one cycle later, o_locked=1.
- All five request continuously, single-flit packets (i_accept=i_tail=1 every cycle) → grant order 0,1,2,3,4,0 back-to-back with no idle cycle.
- Input 2 holds a 4-flit packet; input 0 requests at flit 2; input 2 drops request at flit 3 → o_grant stays 5'b00100 until tail accept, then 5'b00001.
- Tail accepted with only the holder requesting → holder re-granted next cycle; tail with no requests → o_grant=0, o_locked=0.
- Watchdog on, WATCHDOG_CYCLES=8: grant then no i_accept → o_timeout pulse 8 cycles after grant, grant cleared; waiting input 3 granted next arbitration ahead of stalled holder.
- i_rst pulsed asynchronously mid-packet → o_grant=0, o_locked=0 immediately; after release with all requesting, input 0 granted first.
